spmv_sram_arbiter: RTL



---
 rtl/spmv_sram_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/spmv_sram_arbiter.sv
// Round-robin arbiter for the shared single-port SpMV SRAM, with bounded locked bursts and tagged read return.
// Optional: define SPMV_ARB_WB_PRIO_EN to give the writeback port (requester 0) absolute priority in IDLE.
module spmv_sram_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 256,
    parameter int READ_LAT = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_lock,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic                      o_mem_wr_en,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata,
    output logic                      o_busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                          state, state_d;
    logic [PW-1:0]                   owner, owner_d, rr_ptr, rr_ptr_d, win, win_nxt;
    logic [CW-1:0]                   lock_cnt, lock_cnt_d;
    logic [NUM_REQ-1:0]              gnt_d, tag;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_v;
    logic [NUM_REQ-1:0][DATA_W-1:0]  wdata_v;
    logic [ADDR_W-1:0]               addr_q;
    logic [DATA_W-1:0]               wdata_q;
    logic [READ_LAT-1:0][NUM_REQ-1:0] vld_pipe;
    logic                            access, found;
    int                              idx;

    assign addr_v  = i_addr;
    assign wdata_v = i_wdata;
    assign access  = (state == GRANT) && i_req[owner] && !i_rst;
    assign win_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + PW'(1);

    // First requester at or above rr_ptr, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
`ifdef SPMV_ARB_WB_PRIO_EN
        if (i_req[0]) found = 1'b1;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state;
        gnt_d      = o_gnt;
        owner_d    = owner;
        rr_ptr_d   = rr_ptr;
        lock_cnt_d = lock_cnt;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    state_d    = GRANT;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    owner_d    = win;
                    lock_cnt_d = '0;
`ifdef SPMV_ARB_WB_PRIO_EN
                    if (win != '0) rr_ptr_d = win_nxt;
`else
                    rr_ptr_d = win_nxt;
`endif
                end
            end
            GRANT: begin
                if (!i_req[owner]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    lock_cnt_d = lock_cnt + CW'(1);
                    if (!(i_lock[owner] && (int'(lock_cnt) + 1 < MAX_LOCK))) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        tag = '0;
        if (access && !i_we[owner]) tag[owner] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            o_gnt    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            vld_pipe <= '0;
        end else begin
            state       <= state_d;
            o_gnt       <= gnt_d;
            owner       <= owner_d;
            rr_ptr      <= rr_ptr_d;
            lock_cnt    <= lock_cnt_d;
            addr_q      <= o_mem_addr;
            wdata_q     <= o_mem_wdata;
            vld_pipe[0] <= tag;
            for (int i = 1; i < READ_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // SRAM pins hold their last value between accesses so the macro sees no spurious toggles.
    assign o_mem_wr_en = access && i_we[owner];
    assign o_mem_addr  = access ? addr_v[owner]  : addr_q;
    assign o_mem_wdata = access ? wdata_v[owner] : wdata_q;
    assign o_rvalid    = i_rst ? '0 : vld_pipe[READ_LAT-1];
    assign o_rdata     = i_mem_rdata;
    assign o_busy      = (state == GRANT) || (|vld_pipe);
endmodule
